// File: rtl/vga_timing_2018fall.sv
// 640x480@60Hz VGA raster generator and registered pixel output stage for the Pong game.
// Sync and colour share one delay line so they stay aligned for any RGB_LATENCY.
module vga_timing_2018fall #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int RGB_LATENCY = 0
) (
   input  logic        clk25,
   input  logic        Reset_n,
   output logic [9:0]  xpos,
   output logic [9:0]  ypos,
   input  logic [3:0]  red_in,
   input  logic [3:0]  green_in,
   input  logic [3:0]  blue_in,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_tick,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [9:0]  r_xpos;
   logic [9:0]  r_ypos;
   logic [15:0] r_frameCount;
   logic        r_hsync;
   logic        r_vsync;
   logic [11:0] r_rgb;

   logic        w_xLast;
   logic        w_yLast;
   logic [2:0]  w_raw;
   logic [2:0]  w_dly;

   assign w_xLast = (r_xpos == X_LAST);
   assign w_yLast = (r_ypos == Y_LAST);

   always_ff @(posedge clk25 or negedge Reset_n) begin
      if (!Reset_n) begin
         r_xpos <= 10'd0;
         r_ypos <= 10'd0;
      end else if (w_xLast) begin
         r_xpos <= 10'd0;
         r_ypos <= w_yLast ? 10'd0 : r_ypos + 10'd1;
      end else begin
         r_xpos <= r_xpos + 10'd1;
      end
   end

   always_ff @(posedge clk25 or negedge Reset_n) begin
      if (!Reset_n)
         r_frameCount <= 16'd0;
      else if (w_xLast && w_yLast)
         r_frameCount <= r_frameCount + 16'd1;
   end

   // Packed as {visible, hs_n, vs_n}; the idle value 3'b011 means blank with both syncs high.
   assign w_raw = {
      (r_xpos < X_VIS) && (r_ypos < Y_VIS),
      !((r_xpos >= HS_FIRST) && (r_xpos <= HS_LAST)),
      !((r_ypos >= VS_FIRST) && (r_ypos <= VS_LAST))
   };

   generate
      if (RGB_LATENCY == 0) begin : g_noDly
         assign w_dly = w_raw;
      end else begin : g_dly
         logic [2:0] r_stage [RGB_LATENCY];

         always_ff @(posedge clk25 or negedge Reset_n) begin
            if (!Reset_n) begin
               for (int i = 0; i < RGB_LATENCY; i++)
                  r_stage[i] <= 3'b011;
            end else begin
               r_stage[0] <= w_raw;
               for (int i = 1; i < RGB_LATENCY; i++)
                  r_stage[i] <= r_stage[i-1];
            end
         end

         assign w_dly = r_stage[RGB_LATENCY-1];
      end
   endgenerate

   always_ff @(posedge clk25 or negedge Reset_n) begin
      if (!Reset_n) begin
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
         r_rgb   <= 12'd0;
      end else begin
         r_hsync <= w_dly[1];
         r_vsync <= w_dly[0];
         r_rgb   <= w_dly[2] ? {red_in, green_in, blue_in} : 12'd0;
      end
   end

   // The game updates its state here, so the pulse follows the raw counter rather than the delay line.
   assign frame_tick  = (r_xpos == 10'd0) && (r_ypos == Y_VIS);

   assign xpos        = r_xpos;
   assign ypos        = r_ypos;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign vga_r       = r_rgb[11:8];
   assign vga_g       = r_rgb[7:4];
   assign vga_b       = r_rgb[3:0];
   assign frame_count = r_frameCount;

endmodule
